als_sequencer: RTL and testbench
================================

// Module: als_sequencer
// PURPOSE
//   Sequences the combined ALU/shifter unit for the multicycle control path.
//   Accepts one operation request per valid/ready handshake and drives the unit's operation select, operands, ALU_sel, funct and NumberofShifts.
//   For shifts it runs the shift register through load -> shift -> capture.
//   Returns a registered 32-bit result plus flags on a valid/ready response channel; one operation in flight at a time.
// PARAMETERS
//   WIDTH    32  datapath width (fixed by the ALU/shifter unit)
//   SHAMT_W  5   shift-amount width
// PORTS
//   Clk          in   1        single clock, rising edge
//   reset        in   1        synchronous, active-high
//   req_valid    in   1        request present
//   req_ready    out  1        sequencer can accept (high only in IDLE)
//   req_shift    in   1        1 = shift op, 0 = ALU op
//   req_alu_sel  in   3        ALU function code (ALU ops)
//   req_funct    in   3        shift kind: 010 sll, 011 srl, 100 sra, 101 ror, 110 rol
//   req_a        in   WIDTH    ALU operand A / shift source
//   req_b        in   WIDTH    ALU operand B (ignored for shifts)
//   req_shamt    in   SHAMT_W  shift amount
//   operation    out  1        unit select: 0 ALU, 1 shifter
//   oper_A       out  WIDTH    registered ALU operand A
//   oper_B       out  WIDTH    registered ALU operand B
//   ALU_sel      out  3        registered ALU function code
//   funct        out  3        shifter command: 000 hold, 001 load, others as req_funct
//   NumberofShifts out SHAMT_W registered shift amount
//   Array        out  WIDTH    shifter load data
//   ALU_result   in   WIDTH    from ALU
//   alu_flags    in   6        {overflow,negative,zero,equal,greater,lesser} from ALU
//   Shifted_Array in  WIDTH    from shifter
//   rsp_valid    out  1        result available
//   rsp_ready    in   1        consumer accepts result
//   rsp_result   out  WIDTH    registered result
//   rsp_flags    out  6        registered flags, same order as alu_flags
// BEHAVIOUR
//   Reset (any state, mid-op included):
//     state=IDLE; req_ready=1; rsp_valid=0; funct=000; operation=0.
//     oper_A/oper_B/Array/rsp_result=0; ALU_sel=000; NumberofShifts=0; rsp_flags=0.
//     An in-flight op is dropped and no response is produced.
//   FSM states: IDLE, ALU_EXEC, SH_LOAD, SH_RUN, SH_CAP, RESP.
//   IDLE: req_ready=1. On req_valid, register all req_* fields, then:
//     - ALU op -> ALU_EXEC.
//     - shift with req_shamt!=0 -> SH_LOAD.
//     - shift with req_shamt==0 -> RESP; rsp_result=req_a; flags as for a shift.
//   ALU_EXEC (1 cycle): operation=0, operands stable. Capture ALU_result and alu_flags -> RESP.
//   SH_LOAD (1 cycle): operation=1, funct=001, Array=A -> SH_RUN.
//   SH_RUN (1 cycle): funct=stored shift kind, NumberofShifts=shamt -> SH_CAP.
//   SH_CAP (1 cycle): funct=000 (hold). Capture Shifted_Array -> RESP.
//   Shift flags: zero=(result==0); negative=result[WIDTH-1]; all other flags 0.
//   RESP: rsp_valid=1, result and flags held stable.
//     - rsp_ready=1 -> IDLE.
//     - rsp_ready=0 -> stall indefinitely; no new request accepted.
//   Latency, request accept edge to rsp_valid high:
//     ALU 2 cycles; shift 4 cycles; zero-shift 1 cycle.
//   req_ready is low in every state except IDLE, so requests never overlap.
//   No back-to-back accept in the RESP->IDLE cycle: throughput is 1 op per (latency+1) cycles minimum.
//   Invalid req_funct (000,001,111) on a shift op: treated as zero-shift (result=A).
//   funct is 000 in every state other than SH_LOAD and SH_RUN, so shifter contents are never disturbed.
// STRUCTURE
//   Package als_pkg:
//     - state enum als_state_t.
//     - shifter funct constants (SH_NOP, SH_LOAD, SH_SLL, SH_SRL, SH_SRA, SH_ROR, SH_ROL).
//     - ALU_sel constants.
//     - flag index constants.
//   Single module; no sub-module.
//   The ALU/shifter unit is instantiated beside this block by the parent, not inside it.
// TESTING
//   1. ALU add: A=5, B=7, ALU_sel=add -> rsp_valid 2 cycles after accept, result=12, zero=0.
//   2. ALU overflow: A=32'h7FFFFFFF, B=1, add -> result=32'h80000000, overflow=1, negative=1.
//   3. sra: A=32'h80000010, shamt=4 -> funct sequence 001,100,000; result=32'hF8000001 at cycle 4, negative=1.
//   4. Zero shift: sll with shamt=0, A=32'hABCD -> result=32'hABCD at cycle 1; funct stays 000 throughout.
//   5. Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and result held stable, req_ready=0; release -> IDLE next cycle.
//   6. Reset mid-shift (asserted in SH_RUN) -> next cycle IDLE, rsp_valid=0, funct=000; a following ALU op completes normally.

Source files
------------

// File: rtl/als_pkg.sv
`default_nettype none
// ============================================================================
// Package     : als_pkg
// Description : Shared types and constants for the ALU/shifter sequencer:
//               FSM state encoding, shifter command codes, ALU function
//               codes and the bit positions of the flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package als_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALU_EXEC = 3'd1,
        ST_SH_LOAD  = 3'd2,
        ST_SH_RUN   = 3'd3,
        ST_SH_CAP   = 3'd4,
        ST_RESP     = 3'd5
    } als_state_t;

    // Shifter command (funct) codes
    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;
    localparam logic [2:0] SH_ROR  = 3'b101;
    localparam logic [2:0] SH_ROL  = 3'b110;

    // ALU function codes (passed straight through to the ALU)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // Flag vector layout: {overflow,negative,zero,equal,greater,lesser}
    localparam int FLAG_W        = 6;
    localparam int FLAG_OVERFLOW = 5;
    localparam int FLAG_NEGATIVE = 4;
    localparam int FLAG_ZERO     = 3;
    localparam int FLAG_EQUAL    = 2;
    localparam int FLAG_GREATER  = 1;
    localparam int FLAG_LESSER   = 0;

    // True for the funct codes that actually move data in the shifter.
    function automatic logic is_shift_kind(input logic [2:0] kind);
        logic ok;
        case (kind)
            SH_SLL, SH_SRL, SH_SRA, SH_ROR, SH_ROL: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : als_pkg
`default_nettype wire

// File: rtl/als_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : als_sequencer
// Description : Sequences the combined ALU/shifter unit for the multicycle
//               control path. One request at a time is accepted over a
//               valid/ready channel; ALU ops run for one execute cycle,
//               shift ops run the shifter through load -> shift -> capture.
//               The registered result and flags are returned on a
//               valid/ready response channel.
// Ports       : Clk, reset            - clock, synchronous active-high reset
//               req_*                 - request channel (valid/ready)
//               operation, oper_A/B,
//               ALU_sel, funct,
//               NumberofShifts, Array - control/data to the ALU/shifter unit
//               ALU_result, alu_flags,
//               Shifted_Array         - results from the ALU/shifter unit
//               rsp_*                 - response channel (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
module als_sequencer
    import als_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               reset,
    // request channel
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_shift,
    input  logic [2:0]         req_alu_sel,
    input  logic [2:0]         req_funct,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [SHAMT_W-1:0] req_shamt,
    // ALU/shifter unit control
    output logic               operation,
    output logic [WIDTH-1:0]   oper_A,
    output logic [WIDTH-1:0]   oper_B,
    output logic [2:0]         ALU_sel,
    output logic [2:0]         funct,
    output logic [SHAMT_W-1:0] NumberofShifts,
    output logic [WIDTH-1:0]   Array,
    // ALU/shifter unit results
    input  logic [WIDTH-1:0]   ALU_result,
    input  logic [FLAG_W-1:0]  alu_flags,
    input  logic [WIDTH-1:0]   Shifted_Array,
    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [FLAG_W-1:0]  rsp_flags
);

    als_state_t r_state;
    logic [2:0] r_kind;     // stored shift kind, issued during SH_RUN

    // Shift results only carry zero and negative; the rest read as 0.
    function automatic logic [FLAG_W-1:0] shift_flags(input logic [WIDTH-1:0] res);
        logic [FLAG_W-1:0] f;
        f                = '0;
        f[FLAG_ZERO]     = (res == '0);
        f[FLAG_NEGATIVE] = res[WIDTH-1];
        return f;
    endfunction

    // All outputs are registered and set on the edge that enters the state
    // they belong to, so each output is valid for the whole state cycle.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_kind         <= SH_NOP;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            funct          <= SH_NOP;
            operation      <= 1'b0;
            oper_A         <= '0;
            oper_B         <= '0;
            Array          <= '0;
            ALU_sel        <= 3'b000;
            NumberofShifts <= '0;
            rsp_result     <= '0;
            rsp_flags      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        oper_A         <= req_a;
                        oper_B         <= req_b;
                        ALU_sel        <= req_alu_sel;
                        NumberofShifts <= req_shamt;
                        r_kind         <= req_funct;
                        // Array only matters once funct=LOAD, so loading it
                        // for ALU ops as well is harmless.
                        Array          <= req_a;
                        req_ready      <= 1'b0;
                        if (!req_shift) begin
                            r_state <= ST_ALU_EXEC;
                        end else if ((req_shamt == '0) || !is_shift_kind(req_funct)) begin
                            // Nothing to shift: answer with the source
                            // directly and never touch the shifter.
                            r_state    <= ST_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_result <= req_a;
                            rsp_flags  <= shift_flags(req_a);
                        end else begin
                            r_state   <= ST_SH_LOAD;
                            operation <= 1'b1;
                            funct     <= SH_LOAD;
                        end
                    end
                end

                ST_ALU_EXEC: begin
                    r_state    <= ST_RESP;
                    rsp_valid  <= 1'b1;
                    rsp_result <= ALU_result;
                    rsp_flags  <= alu_flags;
                end

                ST_SH_LOAD: begin
                    r_state <= ST_SH_RUN;
                    funct   <= r_kind;
                end

                ST_SH_RUN: begin
                    // Hold so the shifter keeps its result for capture.
                    r_state <= ST_SH_CAP;
                    funct   <= SH_NOP;
                end

                ST_SH_CAP: begin
                    r_state    <= ST_RESP;
                    operation  <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_result <= Shifted_Array;
                    rsp_flags  <= shift_flags(Shifted_Array);
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    funct     <= SH_NOP;
                    operation <= 1'b0;
                end
            endcase
        end
    end

endmodule : als_sequencer
`default_nettype wire

// File: tb/tb_als_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_als_sequencer
// Description : Directed testbench for als_sequencer. A small behavioural
//               ALU and shifter sit beside the DUT the way the parent would
//               wire them; expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_als_sequencer;
    import als_pkg::*;

    logic        Clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_shift;
    logic [2:0]  req_alu_sel, req_funct;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_shamt;
    logic        operation;
    logic [31:0] oper_A, oper_B, Array;
    logic [2:0]  ALU_sel, funct;
    logic [4:0]  NumberofShifts;
    logic [31:0] ALU_result, Shifted_Array;
    logic [5:0]  alu_flags;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [5:0]  rsp_flags;

    always #5 Clk = ~Clk;

    als_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk            (Clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_shift      (req_shift),
        .req_alu_sel    (req_alu_sel),
        .req_funct      (req_funct),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_shamt      (req_shamt),
        .operation      (operation),
        .oper_A         (oper_A),
        .oper_B         (oper_B),
        .ALU_sel        (ALU_sel),
        .funct          (funct),
        .NumberofShifts (NumberofShifts),
        .Array          (Array),
        .ALU_result     (ALU_result),
        .alu_flags      (alu_flags),
        .Shifted_Array  (Shifted_Array),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_flags      (rsp_flags)
    );

    // ---------------- behavioural ALU (add/sub with full flags) -------------
    always_comb begin
        ALU_result = (ALU_sel == ALU_SUB) ? (oper_A - oper_B) : (oper_A + oper_B);
        alu_flags  = 6'b0;
        if (ALU_sel == ALU_SUB)
            alu_flags[FLAG_OVERFLOW] = (oper_A[31] != oper_B[31]) && (ALU_result[31] != oper_A[31]);
        else
            alu_flags[FLAG_OVERFLOW] = (oper_A[31] == oper_B[31]) && (ALU_result[31] != oper_A[31]);
        alu_flags[FLAG_NEGATIVE] = ALU_result[31];
        alu_flags[FLAG_ZERO]     = (ALU_result == 32'd0);
        alu_flags[FLAG_EQUAL]    = (oper_A == oper_B);
        alu_flags[FLAG_GREATER]  = ($signed(oper_A) > $signed(oper_B));
        alu_flags[FLAG_LESSER]   = ($signed(oper_A) < $signed(oper_B));
    end

    // ---------------- behavioural shifter (whole shift in one edge) ---------
    logic [31:0] sh_reg;
    logic [5:0]  sh_inv;
    assign sh_inv        = 6'd32 - {1'b0, NumberofShifts};
    assign Shifted_Array = sh_reg;

    always_ff @(posedge Clk) begin
        case (funct)
            SH_LOAD: sh_reg <= Array;
            SH_SLL:  sh_reg <= sh_reg << NumberofShifts;
            SH_SRL:  sh_reg <= sh_reg >> NumberofShifts;
            SH_SRA:  sh_reg <= $signed(sh_reg) >>> NumberofShifts;
            SH_ROR:  sh_reg <= (sh_reg >> NumberofShifts) | (sh_reg << sh_inv);
            SH_ROL:  sh_reg <= (sh_reg << NumberofShifts) | (sh_reg >> sh_inv);
            default: sh_reg <= sh_reg;
        endcase
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // funct as seen in cycles 1..7 after the accept edge
    logic [2:0] flog [0:7];

    // Issue one request from IDLE (called #1 after an edge) and wait for
    // rsp_valid. lat = cycle after accept in which rsp_valid is seen, 0 on timeout.
    task automatic issue(input logic sh, input logic [2:0] sel, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] n, output int lat);
        req_shift   = sh;
        req_alu_sel = sel;
        req_funct   = fn;
        req_a       = a;
        req_b       = b;
        req_shamt   = n;
        req_valid   = 1'b1;
        for (int i = 0; i < 8; i++) flog[i] = 3'b111;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c < 8) flog[c[2:0]] = funct;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(posedge Clk); #1;
        end
    endtask

    // With rsp_ready high the next edge must return to IDLE.
    task automatic finish_rsp(input string tag);
        @(posedge Clk); #1;
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_funct"}, 32'(funct), 32'(SH_NOP));
    endtask

    int lat;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_shift = 1'b0; req_alu_sel = 3'b0;
        req_funct = 3'b0; req_a = 32'd0; req_b = 32'd0; req_shamt = 5'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        // reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_funct",     32'(funct),     32'd0);
        check("rst_operation", 32'(operation), 32'd0);
        check("rst_result",    rsp_result,     32'd0);
        check("rst_flags",     32'(rsp_flags), 32'd0);
        check("rst_oper_A",    oper_A,         32'd0);
        reset = 1'b0;
        @(posedge Clk); #1;

        // 1. ALU add 5+7
        issue(1'b0, ALU_ADD, 3'b000, 32'd5, 32'd7, 5'd0, lat);
        check("add_latency", 32'(lat), 32'd2);
        check("add_result",  rsp_result, 32'd12);
        check("add_flags",   32'(rsp_flags), 32'(6'b000001));
        check("add_rdy_low", 32'(req_ready), 32'd0);
        finish_rsp("add");

        // 2. ALU overflow
        issue(1'b0, ALU_ADD, 3'b000, 32'h7FFF_FFFF, 32'd1, 5'd0, lat);
        check("ovf_latency", 32'(lat), 32'd2);
        check("ovf_result",  rsp_result, 32'h8000_0000);
        check("ovf_flags",   32'(rsp_flags), 32'(6'b110010));
        finish_rsp("ovf");

        // 3. sra by 4
        issue(1'b1, ALU_ADD, SH_SRA, 32'h8000_0010, 32'hDEAD_BEEF, 5'd4, lat);
        check("sra_latency", 32'(lat), 32'd4);
        check("sra_funct_c1", 32'(flog[1]), 32'(SH_LOAD));
        check("sra_funct_c2", 32'(flog[2]), 32'(SH_SRA));
        check("sra_funct_c3", 32'(flog[3]), 32'(SH_NOP));
        check("sra_funct_c4", 32'(flog[4]), 32'(SH_NOP));
        check("sra_result",  rsp_result, 32'hF800_0001);
        check("sra_flags",   32'(rsp_flags), 32'(6'b010000));
        finish_rsp("sra");

        // ror by 4
        issue(1'b1, ALU_ADD, SH_ROR, 32'h0000_000F, 32'd0, 5'd4, lat);
        check("ror_latency", 32'(lat), 32'd4);
        check("ror_result",  rsp_result, 32'hF000_0000);
        check("ror_flags",   32'(rsp_flags), 32'(6'b010000));
        finish_rsp("ror");

        // 4. zero-amount sll
        issue(1'b1, ALU_ADD, SH_SLL, 32'h0000_ABCD, 32'd0, 5'd0, lat);
        check("zsh_latency", 32'(lat), 32'd1);
        check("zsh_funct_c1", 32'(flog[1]), 32'(SH_NOP));
        check("zsh_oper",    32'(operation), 32'd0);
        check("zsh_result",  rsp_result, 32'h0000_ABCD);
        check("zsh_flags",   32'(rsp_flags), 32'(6'b000000));
        finish_rsp("zsh");

        // invalid shift kind behaves as zero-shift; zero source sets zero flag
        issue(1'b1, ALU_ADD, 3'b111, 32'd0, 32'd0, 5'd3, lat);
        check("inv_latency", 32'(lat), 32'd1);
        check("inv_funct_c1", 32'(flog[1]), 32'(SH_NOP));
        check("inv_result",  rsp_result, 32'd0);
        check("inv_flags",   32'(rsp_flags), 32'(6'b001000));
        finish_rsp("inv");

        // 5. backpressure: hold rsp_ready low for 10 cycles, request pending
        rsp_ready = 1'b0;
        issue(1'b0, ALU_SUB, 3'b000, 32'd10, 32'd3, 5'd0, lat);
        check("bp_latency", 32'(lat), 32'd2);
        req_shift = 1'b0; req_alu_sel = ALU_ADD; req_a = 32'd100; req_b = 32'd200;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid",  32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, 32'd7);
            check("bp_ready",  32'(req_ready), 32'd0);
            @(posedge Clk); #1;
        end
        check("bp_hold_valid",  32'(rsp_valid), 32'd1);
        check("bp_hold_result", rsp_result, 32'd7);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        finish_rsp("bp");

        // 6. reset while in SH_RUN
        req_shift = 1'b1; req_funct = SH_SRA; req_a = 32'h8000_0010; req_shamt = 5'd4;
        req_valid = 1'b1;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(posedge Clk); #1;
        check("mid_funct_run", 32'(funct), 32'(SH_SRA));
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        check("mid_ready",  32'(req_ready), 32'd1);
        check("mid_valid",  32'(rsp_valid), 32'd0);
        check("mid_funct",  32'(funct), 32'(SH_NOP));
        check("mid_oper",   32'(operation), 32'd0);
        check("mid_result", rsp_result, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(1'b0, ALU_ADD, 3'b000, 32'd5, 32'd7, 5'd0, lat);
        check("post_latency", 32'(lat), 32'd2);
        check("post_result",  rsp_result, 32'd12);
        finish_rsp("post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_als_sequencer
`default_nettype wire
